// File: rtl/mul_defs.sv
// Shared op codes, iteration count and sequencer state encoding for the
// multiplier, its HI/LO sequencer and decode.
package mul_defs;

    localparam int MUL_CYCLES = 32;

    localparam logic [5:0] OP_NOP   = 6'b000000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MADDU = 6'b000001;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_OUT   = 6'b111111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

    function automatic logic is_mul_op(input logic [5:0] op);
        return (op == OP_MULTU) || (op == OP_MADDU);
    endfunction

endpackage

// File: rtl/mul_seq_fsm.sv
// Steps the multiplier through start, 31 idle iterations and the OUT cycle;
// flags the capture cycle and whether the result accumulates into HI/LO.
module mul_seq_fsm
    import mul_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opSignal,
    output logic [5:0] mulSignal,
    output logic       busy,
    output logic       start,
    output logic       capture,
    output logic       accumulate
);

    seq_state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       acc_q, acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mulSignal = OP_NOP;
        busy      = 1'b0;
        start     = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A request coinciding with reset is dropped outright.
                if (!rst && is_mul_op(opSignal)) begin
                    start     = 1'b1;
                    busy      = 1'b1;
                    mulSignal = opSignal;
                    acc_d     = (opSignal == OP_MADDU);
                    cnt_d     = 5'd0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(MUL_CYCLES - 2))
                    state_d = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                mulSignal = OP_OUT;
                capture   = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accumulate = acc_q;

endmodule

// File: rtl/hi_lo_unit.sv
// Architectural HI/LO store fed by the iterative multiplier: operand
// registers, overwrite/accumulate on capture, and the MFHI/MFLO read port.
module hi_lo_unit
    import mul_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opSignal,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [63:0] mulResult,
    output logic [5:0]  mulSignal,
    output logic [31:0] mulA,
    output logic [31:0] mulB,
    output logic [31:0] dataOut,
    output logic        busy
);

    logic        start, capture, accumulate;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [31:0] dout_q, dout_d;
    logic [63:0] sum;

    mul_seq_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .opSignal   (opSignal),
        .mulSignal  (mulSignal),
        .busy       (busy),
        .start      (start),
        .capture    (capture),
        .accumulate (accumulate)
    );

    // Carry out of bit 63 is intentionally dropped.
    assign sum = {hi_q, lo_q} + mulResult;

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        dout_d  = 32'd0;
        if (start) begin
            mul_a_d = dataA;
            mul_b_d = dataB;
        end
        if (capture) begin
            {hi_d, lo_d} = accumulate ? sum : mulResult;
        end else if (!busy) begin
            // Moves are only honoured when no multiply is in flight.
            unique case (opSignal)
                OP_MTHI: hi_d   = dataA;
                OP_MTLO: lo_d   = dataA;
                OP_MFHI: dout_d = hi_q;
                OP_MFLO: dout_d = lo_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            mul_a_q <= 32'd0;
            mul_b_q <= 32'd0;
            dout_q  <= 32'd0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            dout_q  <= dout_d;
        end
    end

    assign mulA    = mul_a_q;
    assign mulB    = mul_b_q;
    assign dataOut = dout_q;

endmodule

// File: tb/tb_hi_lo_unit.sv
// Scoreboard bench for hi_lo_unit: a cycle-level reference model queues the
// expected outputs for every cycle; a negedge monitor pops and compares.
module tb_hi_lo_unit;
    import mul_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opSignal;
    logic [31:0] dataA, dataB;
    logic [63:0] mulResult;
    logic [5:0]  mulSignal;
    logic [31:0] mulA, mulB, dataOut;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Stand-in for the multiplier: product of the registered operands.
    assign mulResult = 64'(mulA) * 64'(mulB);

    hi_lo_unit dut (
        .clk       (clk),
        .rst       (rst),
        .opSignal  (opSignal),
        .dataA     (dataA),
        .dataB     (dataB),
        .mulResult (mulResult),
        .mulSignal (mulSignal),
        .mulA      (mulA),
        .mulB      (mulB),
        .dataOut   (dataOut),
        .busy      (busy)
    );

    typedef struct {
        logic [5:0]  sig;
        logic        busy;
        logic [31:0] dout;
        bit          chk_ab;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: phase 0 = idle, 1..32 = cycles after the start cycle.
    int          m_phase = 0;
    bit          m_acc   = 0;
    logic [31:0] m_a = 0, m_b = 0;
    logic [63:0] m_hilo = 0;
    logic [31:0] m_rd = 0;

    task automatic step(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic r);
        exp_t        e;
        logic [31:0] nrd;
        @(posedge clk);
        #1;
        rst = r; opSignal = op; dataA = a; dataB = b;
        e.dout   = m_rd;
        e.chk_ab = (m_phase == 1);
        e.a      = m_a;
        e.b      = m_b;
        if (m_phase == 0) begin
            e.busy = !r && (op == OP_MULTU || op == OP_MADDU);
            e.sig  = e.busy ? op : OP_NOP;
        end else begin
            e.busy = 1'b1;
            e.sig  = (m_phase == 32) ? OP_OUT : OP_NOP;
        end
        exp_q.push_back(e);
        nrd = 32'd0;
        if (r) begin
            m_hilo = 64'd0; m_phase = 0; m_a = 0; m_b = 0;
        end else if (m_phase == 0) begin
            case (op)
                OP_MULTU, OP_MADDU: begin
                    m_acc = (op == OP_MADDU); m_a = a; m_b = b; m_phase = 1;
                end
                OP_MTHI: m_hilo[63:32] = a;
                OP_MTLO: m_hilo[31:0]  = a;
                OP_MFHI: nrd = m_hilo[63:32];
                OP_MFLO: nrd = m_hilo[31:0];
                default: ;
            endcase
        end else if (m_phase == 32) begin
            m_hilo  = m_acc ? m_hilo + 64'(m_a) * 64'(m_b) : 64'(m_a) * 64'(m_b);
            m_phase = 0;
        end else begin
            m_phase++;
        end
        m_rd = nrd;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(OP_NOP, $urandom, $urandom, 1'b0);
    endtask

    task automatic mul_full(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        step(op, a, b, 1'b0);
        nop(32);
    endtask

    // Monitor: one queued expectation per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (busy !== e.busy) begin
                    errors++;
                    $display("FAIL busy: got %b want %b at %0t", busy, e.busy, $time);
                end
                checks++;
                if (mulSignal !== e.sig) begin
                    errors++;
                    $display("FAIL mulSignal: got %b want %b at %0t", mulSignal, e.sig, $time);
                end
                checks++;
                if (dataOut !== e.dout) begin
                    errors++;
                    $display("FAIL dataOut: got %h want %h at %0t", dataOut, e.dout, $time);
                end
                if (e.chk_ab) begin
                    checks++;
                    if (mulA !== e.a || mulB !== e.b) begin
                        errors++;
                        $display("FAIL operands: got %h/%h want %h/%h at %0t",
                                 mulA, mulB, e.a, e.b, $time);
                    end
                end
            end
        end
    end

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        logic [31:0] a, b;
        ops = '{OP_MULTU, OP_MADDU, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO, OP_NOP};
        rst = 1'b1; opSignal = OP_NOP; dataA = 0; dataB = 0;
        step(OP_NOP, 0, 0, 1'b1);
        step(OP_MULTU, 1, 1, 1'b1);     // request under reset is dropped
        nop(2);

        mul_full(OP_MULTU, 3, 5);
        step(OP_MFHI, 0, 0, 0); step(OP_MFLO, 0, 0, 0); nop(1);

        mul_full(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(OP_MFHI, 0, 0, 0); step(OP_MFLO, 0, 0, 0); nop(1);

        step(OP_MTHI, 32'hFFFF_FFFF, 0, 0); step(OP_MTLO, 32'hFFFF_FFFF, 0, 0);
        mul_full(OP_MADDU, 1, 1);
        step(OP_MFHI, 0, 0, 0); step(OP_MFLO, 0, 0, 0);
        mul_full(OP_MADDU, 2, 3);
        step(OP_MFLO, 0, 0, 0); nop(1);

        step(OP_MULTU, 6, 7, 0); nop(4);
        step(OP_MFLO, 0, 0, 0); step(OP_MTLO, 32'hDEAD_BEEF, 0, 0);
        step(OP_MTHI, 32'h1234_5678, 0, 0); nop(25);
        step(OP_MFLO, 0, 0, 0); step(OP_MFHI, 0, 0, 0); nop(1);

        step(OP_MULTU, 7, 9, 0); nop(9);
        step(OP_NOP, 0, 0, 1'b1);
        step(OP_MFLO, 0, 0, 0);
        mul_full(OP_MULTU, 7, 9);
        step(OP_MFLO, 0, 0, 0); nop(1);

        mul_full(OP_MULTU, 4, 4);
        mul_full(OP_MADDU, 2, 2);
        step(OP_MFLO, 0, 0, 0); step(OP_MFHI, 0, 0, 0);

        // Reset landing in the capture cycle must not write HI/LO.
        step(OP_MTLO, 32'h55, 0, 0);
        step(OP_MULTU, 100, 100, 0); nop(31);
        step(OP_NOP, 0, 0, 1'b1);
        step(OP_MFLO, 0, 0, 0); nop(1);

        for (int i = 0; i < 3000; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            step(op, a, b, ($urandom_range(0, 299) == 0));
        end
        nop(2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hi_lo_unit.md
# hi_lo_unit

Sequencer and result store placed directly downstream of the iterative 32-bit `Multiplier`. It accepts MULTU/MADDU requests from decode and drives the multiplier's `Signal` through its 32-iteration run. It then pulses OUT to collect the 64-bit product and writes it to architectural HI/LO, either overwriting them or accumulating into them. It also serves MFHI/MFLO/MTHI/MTLO and raises `busy` so the pipeline stalls while a multiply is in flight.

## Interface
- `MUL_CYCLES`, 32: multiplier iterations before OUT is issued.
- `clk`  in  1  clock; everything updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset; the same net also drives the multiplier's `rst`.
- `opSignal`  in  6  decoded op: MULTU 011001, MADDU 000001, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011; all other codes are no-op.
- `dataA`  in  32  rs value, forwarded to the multiplier and used as the MTHI/MTLO write data.
- `dataB`  in  32  rt value, forwarded to the multiplier.
- `mulResult`  in  64  the multiplier's `dataOut`.
- `mulSignal`  out  6  drives the multiplier's `Signal`.
- `mulA`, `mulB`  out  32 each  registered operands for the multiplier.
- `dataOut`  out  32  MFHI/MFLO read data.
- `busy`  out  1  high while a multiply is in flight.

## Operation
- The FSM has three states: IDLE, RUN, DONE. A 5-bit counter `cnt` runs alongside it.
- IDLE:
  - opSignal MULTU or MADDU: latch the op kind, register dataA/dataB onto mulA/mulB, drive mulSignal = that op for this cycle, set cnt=0, go to RUN.
  - MTHI/MTLO: write dataA into HI/LO at the edge.
  - MFHI/MFLO: dataOut = HI/LO, registered, valid the next cycle.
  - Other codes: dataOut = 0.
- RUN:
  - mulSignal = 000000 and cnt increments each cycle.
  - When cnt = MUL_CYCLES-2, go to DONE.
- DONE:
  - mulSignal = OUT (111111); mulResult is sampled in the same cycle.
  - MULTU latched: {HI,LO} <= mulResult.
  - MADDU latched: {HI,LO} <= {HI,LO} + mulResult, modulo 2^64 with the carry discarded.
  - Return to IDLE.
- Any opSignal other than no-op arriving while in RUN or DONE is ignored: no HI/LO write and dataOut = 0. Upstream must stall on `busy`; this block does not queue requests.
- A MADDU that follows a MULTU back-to-back accumulates onto the just-written HI/LO.

## Timing
- Start cycle T: mulSignal = op, busy = 1 combinationally.
- T+1 to T+31: mulSignal = 000000, busy = 1.
- T+32 (DONE): mulSignal = OUT, busy = 1. HI/LO update at the end of this cycle.
- T+33: back in IDLE with busy = 0; a new request is accepted this cycle. Total latency is 33 cycles.
- MFHI/MFLO issued at T+33 returns the new value at T+34.
- Reset values: state IDLE, cnt 0, HI = LO = 0, mulSignal = 000000, mulA = mulB = 0, dataOut = 0, busy = 0.
- Reset mid-operation, in any cycle of RUN or DONE:
  - abandon the operation with no HI/LO write;
  - all outputs take their reset values the next cycle.
- Reset and a request in the same cycle: reset wins and the request is dropped.
- MTHI/MTLO and MFHI/MFLO are single-cycle and never assert busy.

## Structure
- Shared package/header `mul_defs`, used by this block, the multiplier and decode:
  - the six op codes and OUT;
  - `MUL_CYCLES`;
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- Sub-module `mul_seq_fsm` holds the state register, cnt, mulSignal generation and busy. It emits a one-cycle `capture` and an `accumulate` flag.
- The top level holds HI/LO, the 64-bit adder, the read mux and the operand registers.

## Test plan
- MULTU with dataA=3, dataB=5 at T -> busy high T..T+32, OUT at T+32 only, HI=0x00000000, LO=0x0000000F at T+33.
- MULTU with 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then MFHI -> dataOut=0xFFFFFFFE one cycle later.
- MTHI 0xFFFFFFFF, MTLO 0xFFFFFFFF, then MADDU 1×1 -> HI=LO=0 (64-bit wrap); then MADDU 2×3 -> LO=6.
- MFLO and MTLO 0xDEADBEEF issued at T+5 of a running MULTU -> dataOut=0, LO unchanged until the multiply writes it.
- rst asserted at T+10 of a MULTU 7×9 -> T+11: busy=0, mulSignal=000000, HI=LO=0; a fresh MULTU 7×9 then yields LO=63.
- Back-to-back: MULTU 4×4 then MADDU 2×2 issued at T+33 -> LO=20 at T+66.
